nmr_bstrm_sram_arb: RTL and testbench
=====================================

// Module: nmr_bstrm_sram_arb
// PURPOSE
//  Shares the single bitstream program SRAM (on-chip RAM) between two requesters:
//  - host port H: read/write, used to load sequences;
//  - bitstream engine port E: read-only, the sequence-fetch side.
//  Registered single-port SRAM master; tags in-flight reads and routes return data to the issuer.
//  E_LOCK gives the engine exclusive access during a running sequence so pulse timing never stalls.
// PARAMETERS
//  SRAM_ADDR_WIDTH    8    SRAM word address width
//  SRAM_DAT_WIDTH     128  SRAM data width
//  SRAM_BYTEEN_WIDTH  16   byte-enable width (SRAM_DAT_WIDTH/8)
//  RD_LAT             2    SRAM read latency, cycles from registered SRAM_CS to valid SRAM_RD_DAT (1..4)
//  STAT_WIDTH         32   stall-counter width (ARB_STATS_EN only)
// PORTS
//  CLK          in   1    system clock; single clock domain
//  RST          in   1    asynchronous, active-low reset
//  H_ADDR       in   AW   host word address
//  H_RD         in   1    host read request, held until accepted
//  H_WR         in   1    host write request, held until accepted; H_RD&H_WR illegal
//  H_WDAT       in   DW   host write data
//  H_BYTEEN     in   BW   host byte enables
//  H_WAIT       out  1    host stall; request accepted in a cycle with (H_RD|H_WR)&!H_WAIT
//  H_RDAT       out  DW   host read data, valid with H_RVALID
//  H_RVALID     out  1    one-cycle pulse per accepted host read
//  E_ADDR       in   AW   engine word address
//  E_RD         in   1    engine read request
//  E_LOCK       in   1    engine exclusive-access request (sequence running)
//  E_GNT        out  1    engine request accepted this cycle
//  E_RDAT       out  DW   engine read data, valid with E_RVALID
//  E_RVALID     out  1    one-cycle pulse per accepted engine read
//  SRAM_ADDR    out  AW   SRAM address
//  SRAM_CS      out  1    SRAM chip select, one access per cycle
//  SRAM_CLKEN   out  1    SRAM clock enable
//  SRAM_WR      out  1    SRAM write strobe
//  SRAM_WR_DAT  out  DW   SRAM write data
//  SRAM_BYTEEN  out  BW   SRAM byte enables
//  SRAM_RD_DAT  in   DW   SRAM read data
// BEHAVIOUR
//  Reset (RST=0):
//  - All SRAM_* outputs = 0; H_RVALID = E_RVALID = 0; H_RDAT = E_RDAT = 0.
//  - Tag pipeline cleared; reads in flight are discarded and never produce RVALID.
//  - RR pointer set to "engine next".
//  - SRAM_CLKEN = 1 from the first clock edge after reset release.
//  FSM (registered), 3 states:
//  - RR: both ports served round-robin.
//    - Single requester: granted.
//    - H and E same cycle: grant the port not granted last; pointer updates on each grant.
//    - E_LOCK=1 -> LOCK.
//  - LOCK: only E served. H_WAIT = H_RD|H_WR.
//    - E_LOCK=0 -> HAND.
//  - HAND: one cycle, H has absolute priority (post-sequence starvation relief); E waits if H requests.
//    - Next state: RR. If E_LOCK re-asserts in HAND: still -> RR for one cycle, then LOCK.
//  Grant decode (combinational, from current state and requests):
//  - H_WAIT = (H_RD|H_WR) & !grant_h.
//  - E_GNT = E_RD & grant_e.
//  - E_RD while unlocked is legal and arbitrated.
//  Issue: accepted request is registered onto SRAM_* the next cycle (1 cycle issue latency).
//  - Engine: SRAM_WR=0, SRAM_BYTEEN all 1s.
//  - Host write: H_WDAT/H_BYTEEN passed through; no RVALID.
//  - No request accepted: SRAM_CS=0, SRAM_WR=0.
//  Return path: RD_LAT-deep shift register of {valid, tag}.
//  - RDAT/RVALID registered: accept -> RVALID = RD_LAT+2 cycles.
//  - Read data is returned in issue order.
//  - H_RDAT/E_RDAT hold their last value when not valid.
//  Throughput: one access per cycle, no bubbles between back-to-back grants.
// CONFIGURATION
//  ARB_STATS_EN defined:
//  - adds ports STAT_CLR in 1 and STAT_HSTALL out STAT_WIDTH.
//  - STAT_HSTALL counts cycles with H_WAIT=1; saturates at all-1s, never wraps.
//  - STAT_CLR=1 forces 0, taking priority over the increment in the same cycle.
//  - Reset value 0.
//  ARB_STATS_EN undefined: those ports and the counter do not exist; all other behaviour identical.
// TESTING
//  1 Reset: hold RST=0 while H_WR=1, E_RD=1 -> all SRAM_*=0, no RVALID; release -> SRAM_CLKEN=1 next edge.
//  2 Host write/read: H_WR addr 0x05 data 0xA5..A5, then H_RD 0x05
//    -> SRAM_WR pulse 1 cycle after accept; H_RVALID 4 cycles (RD_LAT=2) after read accept, H_RDAT=0xA5..A5.
//  3 Contention unlocked: H_RD 0x10 and E_RD 0x20 held 4 cycles from reset
//    -> grants alternate E,H,E,H; SRAM_ADDR 0x20,0x10,0x20,0x10; each RVALID on the correct port only.
//  4 Lock: E_LOCK=1, E_RD streaming 0x00..0x0F while H_WR held -> H_WAIT=1 for all 16 cycles, zero host SRAM writes;
//    drop E_LOCK -> host write issued in HAND cycle even with E_RD=1.
//  5 Reset mid-flight: assert RST one cycle after engine read accepted
//    -> no E_RVALID ever appears for it; post-reset grant order restarts engine-first.
//  6 ARB_STATS_EN: 10 stalled host cycles -> STAT_HSTALL=10;
//    STAT_CLR with concurrent stall -> 0; STAT_WIDTH=4 with 20 stalls -> 15.

Source files
------------

// File: rtl/nmr_bstrm_sram_arb.sv
// Bitstream program SRAM arbiter: host (read/write) vs. sequence engine (read-only), with an engine lock and a one-cycle host handover.
// Define ARB_STATS_EN to add the host-stall counter ports stat_clr / stat_hstall.
module nmr_bstrm_sram_arb #(
  parameter int SRAM_ADDR_WIDTH   = 8,
  parameter int SRAM_DAT_WIDTH    = 128,
  parameter int SRAM_BYTEEN_WIDTH = 16,
  parameter int RD_LAT            = 2,
  parameter int STAT_WIDTH        = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [SRAM_ADDR_WIDTH-1:0]   h_addr,
  input  logic                         h_rd,
  input  logic                         h_wr,
  input  logic [SRAM_DAT_WIDTH-1:0]    h_wdat,
  input  logic [SRAM_BYTEEN_WIDTH-1:0] h_byteen,
  output logic                         h_wait,
  output logic [SRAM_DAT_WIDTH-1:0]    h_rdat,
  output logic                         h_rvalid,
  input  logic [SRAM_ADDR_WIDTH-1:0]   e_addr,
  input  logic                         e_rd,
  input  logic                         e_lock,
  output logic                         e_gnt,
  output logic [SRAM_DAT_WIDTH-1:0]    e_rdat,
  output logic                         e_rvalid,
  output logic [SRAM_ADDR_WIDTH-1:0]   sram_addr,
  output logic                         sram_cs,
  output logic                         sram_clken,
  output logic                         sram_wr,
  output logic [SRAM_DAT_WIDTH-1:0]    sram_wr_dat,
  output logic [SRAM_BYTEEN_WIDTH-1:0] sram_byteen,
`ifdef ARB_STATS_EN
  input  logic                         stat_clr,
  output logic [STAT_WIDTH-1:0]        stat_hstall,
`endif
  input  logic [SRAM_DAT_WIDTH-1:0]    sram_rd_dat
);

  typedef enum logic [1:0] {
    ST_RR   = 2'd0,
    ST_LOCK = 2'd1,
    ST_HAND = 2'd2
  } arb_state_e;

  arb_state_e state;
  logic       e_next;      // round-robin pointer: engine wins the next tie
  logic       req_h;
  logic       grant_h;
  logic       grant_e;
  logic       issue_host;  // tag of the access currently on the SRAM pins

  logic [RD_LAT-1:0] pipe_v;
  logic [RD_LAT-1:0] pipe_h;

  assign req_h  = h_rd | h_wr;
  assign h_wait = req_h & ~grant_h;
  assign e_gnt  = grant_e;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    grant_h = 1'b0;
    grant_e = 1'b0;
    case (state)
      ST_RR: begin
        if (req_h && e_rd) begin
          grant_e = e_next;
          grant_h = ~e_next;
        end else begin
          grant_h = req_h;
          grant_e = e_rd;
        end
      end
      ST_LOCK: grant_e = e_rd;
      ST_HAND: begin
        grant_h = req_h;
        grant_e = e_rd & ~req_h;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_RR;
      e_next      <= 1'b1;
      sram_clken  <= 1'b0;
      sram_cs     <= 1'b0;
      sram_wr     <= 1'b0;
      sram_addr   <= '0;
      sram_wr_dat <= '0;
      sram_byteen <= '0;
      issue_host  <= 1'b0;
    end else begin
      sram_clken <= 1'b1;

      case (state)
        ST_RR:   if (e_lock)  state <= ST_LOCK;
        ST_LOCK: if (!e_lock) state <= ST_HAND;
        default: state <= ST_RR;  // handover lasts exactly one cycle, even if the lock re-asserts
      endcase

      sram_cs <= grant_h | grant_e;
      sram_wr <= grant_h & h_wr;
      if (grant_h) begin
        sram_addr   <= h_addr;
        sram_wr_dat <= h_wdat;
        sram_byteen <= h_byteen;
        issue_host  <= 1'b1;
        e_next      <= 1'b1;
      end else if (grant_e) begin
        sram_addr   <= e_addr;
        sram_wr_dat <= '0;
        sram_byteen <= '1;
        issue_host  <= 1'b0;
        e_next      <= 1'b0;
      end
    end
  end

  // Tags enter the pipe from the issue register, so the last stage lines up with valid sram_rd_dat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_v   <= '0;
      pipe_h   <= '0;
      h_rvalid <= 1'b0;
      e_rvalid <= 1'b0;
      h_rdat   <= '0;
      e_rdat   <= '0;
    end else begin
      pipe_v[0] <= sram_cs & ~sram_wr;
      pipe_h[0] <= issue_host;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_h[i] <= pipe_h[i-1];
      end
      h_rvalid <= pipe_v[RD_LAT-1] & pipe_h[RD_LAT-1];
      e_rvalid <= pipe_v[RD_LAT-1] & ~pipe_h[RD_LAT-1];
      if (pipe_v[RD_LAT-1] && pipe_h[RD_LAT-1])  h_rdat <= sram_rd_dat;
      if (pipe_v[RD_LAT-1] && !pipe_h[RD_LAT-1]) e_rdat <= sram_rd_dat;
    end
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_hstall <= '0;
    end else if (stat_clr) begin
      stat_hstall <= '0;
    end else if (h_wait && (stat_hstall != '1)) begin
      stat_hstall <= stat_hstall + STAT_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_nmr_bstrm_sram_arb.sv
// Bench for nmr_bstrm_sram_arb: SRAM model with RD_LAT read latency, a transaction-level reference
// model checked every cycle, and directed scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_nmr_bstrm_sram_arb;
  localparam int AW = 8, DW = 128, BW = 16, RD_LAT = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] h_addr = '0;
  logic          h_rd = 1'b0, h_wr = 1'b0;
  logic [DW-1:0] h_wdat = '0;
  logic [BW-1:0] h_byteen = '0;
  logic          h_wait, h_rvalid;
  logic [DW-1:0] h_rdat;
  logic [AW-1:0] e_addr = '0;
  logic          e_rd = 1'b0, e_lock = 1'b0;
  logic          e_gnt, e_rvalid;
  logic [DW-1:0] e_rdat;
  logic [AW-1:0] sram_addr;
  logic          sram_cs, sram_clken, sram_wr;
  logic [DW-1:0] sram_wr_dat, sram_rd_dat;
  logic [BW-1:0] sram_byteen;
`ifdef ARB_STATS_EN
  logic          stat_clr = 1'b0;
  logic [31:0]   stat_hstall;
  logic [3:0]    s_stat;
  logic          s_h_wait, s_h_rvalid, s_e_gnt, s_e_rvalid, s_cs, s_clken, s_wr;
  logic [DW-1:0] s_h_rdat, s_e_rdat, s_wr_dat;
  logic [AW-1:0] s_addr;
  logic [BW-1:0] s_byteen;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  nmr_bstrm_sram_arb #(.RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .h_addr(h_addr), .h_rd(h_rd), .h_wr(h_wr), .h_wdat(h_wdat), .h_byteen(h_byteen),
    .h_wait(h_wait), .h_rdat(h_rdat), .h_rvalid(h_rvalid),
    .e_addr(e_addr), .e_rd(e_rd), .e_lock(e_lock), .e_gnt(e_gnt), .e_rdat(e_rdat), .e_rvalid(e_rvalid),
    .sram_addr(sram_addr), .sram_cs(sram_cs), .sram_clken(sram_clken), .sram_wr(sram_wr),
    .sram_wr_dat(sram_wr_dat), .sram_byteen(sram_byteen),
`ifdef ARB_STATS_EN
    .stat_clr(stat_clr), .stat_hstall(stat_hstall),
`endif
    .sram_rd_dat(sram_rd_dat)
  );

`ifdef ARB_STATS_EN
  nmr_bstrm_sram_arb #(.RD_LAT(RD_LAT), .STAT_WIDTH(4)) dut_small (
    .clk(clk), .rst(rst),
    .h_addr(h_addr), .h_rd(h_rd), .h_wr(h_wr), .h_wdat(h_wdat), .h_byteen(h_byteen),
    .h_wait(s_h_wait), .h_rdat(s_h_rdat), .h_rvalid(s_h_rvalid),
    .e_addr(e_addr), .e_rd(e_rd), .e_lock(e_lock), .e_gnt(s_e_gnt), .e_rdat(s_e_rdat), .e_rvalid(s_e_rvalid),
    .sram_addr(s_addr), .sram_cs(s_cs), .sram_clken(s_clken), .sram_wr(s_wr),
    .sram_wr_dat(s_wr_dat), .sram_byteen(s_byteen),
    .stat_clr(stat_clr), .stat_hstall(s_stat),
    .sram_rd_dat(sram_rd_dat)
  );
`endif

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    return {16{a ^ 8'h5A}};
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [BW-1:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < BW; b++) if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  // SRAM model: data for an access whose chip select is visible in cycle c appears in cycle c+RD_LAT.
  logic [DW-1:0] sram_mem [256];
  logic [DW-1:0] rd_pipe [RD_LAT];
  initial begin
    for (int a = 0; a < 256; a++) sram_mem[a] = init_word(a[7:0]);
    for (int i = 0; i < RD_LAT; i++) rd_pipe[i] = '0;
  end
  always @(posedge clk) begin
    for (int i = RD_LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
    if (sram_clken && sram_cs && !sram_wr) rd_pipe[0] <= sram_mem[sram_addr];
    if (sram_clken && sram_cs && sram_wr)
      sram_mem[sram_addr] <= merge(sram_mem[sram_addr], sram_wr_dat, sram_byteen);
  end
  assign sram_rd_dat = rd_pipe[RD_LAT-1];

  // Reference model: decides who is served each cycle and schedules the resulting pin activity.
  typedef struct { logic [AW-1:0] addr; logic wr; logic [BW-1:0] be; logic [DW-1:0] wd; } issue_t;
  typedef struct { bit host; logic [DW-1:0] dat; } ret_t;

  issue_t        exp_issue [int];
  ret_t          exp_ret   [int];
  logic [DW-1:0] model_mem [256];
  logic [DW-1:0] m_h_rdat, m_e_rdat;
  int            cyc;
  bit            m_excl, m_hand, m_last_host, nx_excl;
  bit            hreq, gh, ge, hv, ev;
  issue_t        iss;
  ret_t          rr;
`ifdef ARB_STATS_EN
  logic [31:0]   m_stat;
`endif

  initial for (int a = 0; a < 256; a++) model_mem[a] = init_word(a[7:0]);

  always @(negedge clk) begin
    if (!rst) begin
      cyc = -1; m_excl = 0; m_hand = 0; m_last_host = 1;
      m_h_rdat = '0; m_e_rdat = '0;
      exp_issue.delete(); exp_ret.delete();
      check("rst_sram_ctl", {sram_cs, sram_clken, sram_wr, sram_addr, sram_byteen}, '0);
      check("rst_sram_wdat", sram_wr_dat, '0);
      check("rst_rvalid", {h_rvalid, e_rvalid}, 2'b00);
      check("rst_rdat", h_rdat | e_rdat, '0);
`ifdef ARB_STATS_EN
      m_stat = '0;
      check("rst_stat", stat_hstall, '0);
`endif
    end else begin
      cyc++;
      check("sram_clken", sram_clken, cyc > 0);

      if (exp_issue.exists(cyc)) begin
        iss = exp_issue[cyc];
        exp_issue.delete(cyc);
        check("sram_cs", sram_cs, 1'b1);
        check("sram_addr", sram_addr, iss.addr);
        check("sram_wr", sram_wr, iss.wr);
        check("sram_byteen", sram_byteen, iss.be);
        if (iss.wr) check("sram_wr_dat", sram_wr_dat, iss.wd);
      end else begin
        check("sram_idle", {sram_cs, sram_wr}, 2'b00);
      end

      hv = 0; ev = 0;
      if (exp_ret.exists(cyc)) begin
        rr = exp_ret[cyc];
        exp_ret.delete(cyc);
        if (rr.host) begin hv = 1; m_h_rdat = rr.dat; end
        else         begin ev = 1; m_e_rdat = rr.dat; end
      end
      check("h_rvalid", h_rvalid, hv);
      check("e_rvalid", e_rvalid, ev);
      check("h_rdat", h_rdat, m_h_rdat);
      check("e_rdat", e_rdat, m_e_rdat);

      hreq = h_rd | h_wr;
      if (m_excl)              begin gh = 0;    ge = e_rd;          end
      else if (m_hand)         begin gh = hreq; ge = e_rd && !hreq; end
      else if (hreq && e_rd)   begin ge = m_last_host; gh = !m_last_host; end
      else                     begin gh = hreq; ge = e_rd;          end
      check("h_wait", h_wait, hreq && !gh);
      check("e_gnt", e_gnt, ge);

`ifdef ARB_STATS_EN
      check("stat_hstall", stat_hstall, m_stat);
      if (stat_clr) m_stat = '0;
      else if (hreq && !gh && m_stat != 32'hFFFF_FFFF) m_stat = m_stat + 1;
`endif

      if (gh) begin
        exp_issue[cyc+1] = '{addr: h_addr, wr: h_wr, be: h_byteen, wd: h_wdat};
        if (h_rd) exp_ret[cyc+RD_LAT+2] = '{host: 1'b1, dat: model_mem[h_addr]};
        if (h_wr) model_mem[h_addr] = merge(model_mem[h_addr], h_wdat, h_byteen);
        m_last_host = 1;
      end else if (ge) begin
        exp_issue[cyc+1] = '{addr: e_addr, wr: 1'b0, be: '1, wd: '0};
        exp_ret[cyc+RD_LAT+2] = '{host: 1'b0, dat: model_mem[e_addr]};
        m_last_host = 0;
      end

      // Engine is exclusive while the lock is held; the cycle after the lock drops belongs to the host.
      nx_excl = m_excl ? e_lock : (!m_hand && e_lock);
      m_hand  = m_excl && !e_lock;
      m_excl  = nx_excl;
    end
  end

  task automatic idle_inputs();
    h_rd = 0; h_wr = 0; e_rd = 0; e_lock = 0;
    h_addr = '0; e_addr = '0; h_wdat = '0; h_byteen = '0;
`ifdef ARB_STATS_EN
    stat_clr = 0;
`endif
  endtask

  // Leaves the caller 1 ns after the first edge following release (start of cycle 0).
  task automatic do_reset();
    rst = 0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1 rst = 1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  int lat, stalls, hwr_cnt, ev_cnt;
  logic [AW-1:0] t3_addr [4];

  initial begin
    t3_addr = '{8'h20, 8'h10, 8'h20, 8'h10};

    // 1: reset with requests pending
    rst = 0;
    h_wr = 1; h_addr = 8'h05; e_rd = 1; e_addr = 8'h06;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("t1_rst_cs", {sram_cs, sram_wr, sram_clken}, 3'b000);
    check("t1_rst_rvalid", {h_rvalid, e_rvalid}, 2'b00);
    next_cycle();
    h_wr = 0; e_rd = 0;
    rst = 1;
    @(negedge clk);
    check("t1_clken_before_edge", sram_clken, 1'b0);
    next_cycle();
    @(negedge clk);
    check("t1_clken_after_edge", sram_clken, 1'b1);
    next_cycle();

    // 2: host write then read of 0x05
    do_reset();
    h_wr = 1; h_addr = 8'h05; h_wdat = {16{8'hA5}}; h_byteen = '1;
    @(negedge clk);
    check("t2_wr_accept", h_wait, 1'b0);
    next_cycle();
    h_wr = 0;
    @(negedge clk);
    check("t2_wr_pulse", {sram_cs, sram_wr, sram_addr}, {2'b11, 8'h05});
    next_cycle();
    @(negedge clk);
    check("t2_wr_single", sram_wr, 1'b0);
    next_cycle();
    h_rd = 1;
    @(negedge clk);
    check("t2_rd_accept", h_wait, 1'b0);
    lat = 0;
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      next_cycle();
      h_rd = 0;
      @(negedge clk);
      if (h_rvalid) lat = i;
    end
    check("t2_rd_latency", lat, 4);
    check("t2_rd_data", h_rdat, {16{8'hA5}});
    repeat (3) next_cycle();

    // 3: contention without lock, both held for four cycles from reset
    do_reset();
    h_rd = 1; h_addr = 8'h10; e_rd = 1; e_addr = 8'h20;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (i < 4) check($sformatf("t3_e_gnt_%0d", i), {e_gnt, h_wait}, (i % 2 == 0) ? 2'b11 : 2'b00);
      if (i >= 1 && i <= 4) check($sformatf("t3_addr_%0d", i), sram_addr, t3_addr[i-1]);
      if (i >= 4 && i <= 7)
        check($sformatf("t3_rvalid_%0d", i), {h_rvalid, e_rvalid}, (i % 2 == 0) ? 2'b01 : 2'b10);
      next_cycle();
      if (i == 3) begin h_rd = 0; e_rd = 0; end
    end

    // 4: engine lock starves the host; host write goes out in the handover cycle
    do_reset();
    e_lock = 1;
    @(negedge clk);
    next_cycle();
    h_wr = 1; h_addr = 8'h33; h_wdat = {16{8'h5A}}; h_byteen = 16'h00FF; e_rd = 1;
    stalls = 0; hwr_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      e_addr = i[7:0];
      @(negedge clk);
      if (h_wait) stalls++;
      if (sram_wr) hwr_cnt++;
      next_cycle();
    end
    check("t4_stalls", stalls, 16);
    e_lock = 0; e_addr = 8'h10;
    @(negedge clk);
    if (sram_wr) hwr_cnt++;
    check("t4_no_host_wr", hwr_cnt, 0);
    check("t4_lock_tail_wait", h_wait, 1'b1);
    next_cycle();
    @(negedge clk);
    check("t4_hand", {h_wait, e_gnt}, 2'b00);
    next_cycle();
    h_wr = 0; e_rd = 0;
    @(negedge clk);
    check("t4_hand_issue", {sram_cs, sram_wr, sram_addr}, {2'b11, 8'h33});
    repeat (6) next_cycle();

    // 5: reset while an engine read is in flight
    do_reset();
    e_rd = 1; e_addr = 8'h07;
    @(negedge clk);
    check("t5_e_accept", e_gnt, 1'b1);
    next_cycle();
    e_rd = 0;
    @(negedge clk);
    check("t5_issue", sram_cs, 1'b1);
    next_cycle();
    rst = 0;
    ev_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i <= 4 && e_rvalid) ev_cnt++;
      if (i == 2) check("t5_restart_engine_first", {e_gnt, h_wait}, 2'b11);
      next_cycle();
      if (i == 1) begin rst = 1; h_rd = 1; h_addr = 8'h40; e_rd = 1; e_addr = 8'h41; end
      if (i == 3) begin h_rd = 0; e_rd = 0; end
    end
    check("t5_no_stale_rvalid", ev_cnt, 0);

`ifdef ARB_STATS_EN
    // 6: host-stall counter, clear priority, 4-bit saturation
    do_reset();
    e_lock = 1;
    @(negedge clk);
    next_cycle();
    h_wr = 1; h_addr = 8'h60; h_wdat = {16{8'hC3}}; h_byteen = '1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 11) check("t6_stat_10", stat_hstall, 10);
      next_cycle();
    end
    stat_clr = 1;
    @(negedge clk);
    check("t6_stat_20", stat_hstall, 20);
    check("t6_stat_sat4", s_stat, 4'hF);
    next_cycle();
    stat_clr = 0; h_wr = 0;
    @(negedge clk);
    check("t6_stat_clr", stat_hstall, 0);
    next_cycle();
    e_lock = 0;
    repeat (4) next_cycle();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
